// File: rtl/exp6_mostra_sequencia.sv
// Sequence presenter for the memory game: plays a fixed 16-entry one-hot ROM onto
// the leds, one entry at a time with fixed lit/blank times, then raises pronto.
module exp6_mostra_sequencia #(
  parameter int ON_CYCLES  = 500,
  parameter int OFF_CYCLES = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  output logic [3:0] leds,
  output logic       mostrando,
  output logic       pronto,
  output logic [3:0] db_endereco,
  output logic [3:0] db_estado
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    ACENDE     = 4'h2,
    APAGA      = 4'h3,
    PROXIMO    = 4'h4,
    FIM        = 4'hF
  } estado_t;

  estado_t       state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [3:0]    limite_q, limite_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    leds_q, leds_d;
  logic          mostrando_q, mostrando_d;
  logic          pronto_q, pronto_d;

  function automatic logic [3:0] rom(input logic [3:0] a);
    case (a)
      4'd0:  rom = 4'b0001;
      4'd1:  rom = 4'b0010;
      4'd2:  rom = 4'b0100;
      4'd3:  rom = 4'b1000;
      4'd4:  rom = 4'b0100;
      4'd5:  rom = 4'b0010;
      4'd6:  rom = 4'b0001;
      4'd7:  rom = 4'b0001;
      4'd8:  rom = 4'b0010;
      4'd9:  rom = 4'b0010;
      4'd10: rom = 4'b0100;
      4'd11: rom = 4'b0100;
      4'd12: rom = 4'b1000;
      4'd13: rom = 4'b1000;
      4'd14: rom = 4'b0001;
      4'd15: rom = 4'b0100;
      default: rom = 4'b0000;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    limite_d = limite_q;
    timer_d  = timer_q;
    case (state_q)
      INICIAL, FIM: begin
        if (iniciar) begin
          state_d  = PREPARACAO;
          limite_d = limite;
        end
      end
      PREPARACAO: begin
        addr_d  = 4'd0;
        timer_d = '0;
        state_d = ACENDE;
      end
      ACENDE: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = APAGA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      APAGA: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          state_d = (addr_q == limite_q) ? FIM : PROXIMO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PROXIMO: begin
        addr_d  = addr_q + 4'd1;
        timer_d = '0;
        state_d = ACENDE;
      end
      default: begin
        timer_d = '0;
        state_d = INICIAL;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    leds_d      = (state_d == ACENDE) ? rom(addr_d) : 4'b0000;
    mostrando_d = (state_d == PREPARACAO) || (state_d == ACENDE) ||
                  (state_d == APAGA) || (state_d == PROXIMO);
    pronto_d    = (state_d == FIM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= INICIAL;
      addr_q      <= 4'd0;
      limite_q    <= 4'd0;
      timer_q     <= '0;
      leds_q      <= 4'b0000;
      mostrando_q <= 1'b0;
      pronto_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      limite_q    <= limite_d;
      timer_q     <= timer_d;
      leds_q      <= leds_d;
      mostrando_q <= mostrando_d;
      pronto_q    <= pronto_d;
    end
  end

  assign leds        = leds_q;
  assign mostrando   = mostrando_q;
  assign pronto      = pronto_q;
  assign db_endereco = addr_q;
  assign db_estado   = state_q;

endmodule
